instr_fifo: RTL and testbench

- Synchronous single-clock FIFO buffering 64-bit fetch packets (two 32-bit instructions) between the fetch stage and the decode stage of the superscalar pipeline.
- The producer pushes with `write`. The consumer pops with `read` unless the pipeline `stall` is asserted.
- `data_out` is a registered output that holds the most recently popped entry.
- `buf_full` back-pressures fetch.

---
 rtl/instr_fifo_pkg.sv | 9 +
 rtl/instr_fifo_if.sv | 25 ++
 rtl/instr_fifo.sv | 68 ++++++
 tb/tb_instr_fifo.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/instr_fifo_pkg.sv
// Shared fetch-path types for the fetch-to-decode instruction buffer.
package instr_fifo_pkg;

  localparam int FETCH_W = 64;

  // One fetch packet carries two 32-bit instructions.
  typedef logic [FETCH_W-1:0] fetch_t;

endpackage

// File: rtl/instr_fifo_if.sv
// Handshake bundle between fetch/decode (master) and the instruction FIFO (slave).
interface instr_fifo_if
  import instr_fifo_pkg::*;
#(
  parameter int WIDTH = FETCH_W
);

  logic [WIDTH-1:0] data_in;
  logic             write;
  logic             read;
  logic             stall;
  logic [WIDTH-1:0] data_out;
  logic             buf_full;

  modport master (
    output data_in, write, read, stall,
    input  data_out, buf_full
  );

  modport slave (
    input  data_in, write, read, stall,
    output data_out, buf_full
  );

endinterface

// File: rtl/instr_fifo.sv
// Single-clock FIFO of fetch packets; data_out is a register loaded only on a pop.
module instr_fifo
  import instr_fifo_pkg::*;
#(
  parameter int WIDTH = FETCH_W,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fifo_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] data_out_reg;
  logic             buf_full;
  logic             do_push;
  logic             do_pop;

  assign buf_full = (count_reg == CNT_W'(DEPTH));

  // A full FIFO drops the write even when a pop frees a slot on the same edge.
  assign do_push = bus.write & ~buf_full;
  assign do_pop  = bus.read & ~bus.stall & (count_reg != '0);

  assign bus.data_out = data_out_reg;
  assign bus.buf_full = buf_full;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage is not reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      data_out_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (do_pop) data_out_reg <= mem[rd_ptr_reg];
    end
  end

endmodule

// File: tb/tb_instr_fifo.sv
// Directed bench for instr_fifo: vector table plus hand-written fill, wrap and reset sequences.
module tb_instr_fifo;
  import instr_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instr_fifo_if #(.WIDTH(FETCH_W)) bus ();

  instr_fifo #(.WIDTH(FETCH_W), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic   write;
    logic   read;
    logic   stall;
    fetch_t din;
    fetch_t exp_dout;
    logic   exp_full;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input fetch_t act, input fetch_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1 ns later.
  task automatic step(input logic w, input logic r, input logic s, input fetch_t d);
    bus.write   = w;
    bus.read    = r;
    bus.stall   = s;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Streaming, stall, full with simultaneous read/write, then drain and empty read.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 64'd10, 64'hABCD, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 64'd20, 64'd10,   1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 64'd30, 64'd20,   1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 64'd31, 64'd20,   1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 64'd32, 64'd20,   1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 64'd33, 64'd20,   1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 64'd34, 64'd20,   1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 64'd35, 64'd20,   1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 64'd36, 64'd20,   1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 64'd37, 64'd20,   1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 64'd99, 64'd20,   1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 64'd77, 64'd30,   1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 64'd0,  64'd30,   1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 64'd0,  64'd31,   1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 64'd0,  64'd32,   1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 64'd0,  64'd33,   1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 64'd0,  64'd34,   1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 64'd0,  64'd35,   1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 64'd0,  64'd36,   1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 64'd0,  64'd37,   1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 64'd0,  64'd37,   1'b0};

    // Reset held for two edges with write asserted.
    bus.write   = 1'b1;
    bus.read    = 1'b0;
    bus.stall   = 1'b0;
    bus.data_in = 64'hABCD;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset data_out", bus.data_out, 64'd0);
    check("reset buf_full", fetch_t'(bus.buf_full), 64'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 64'hABCD);
    check("first push not full", fetch_t'(bus.buf_full), 64'd0);
    step(1'b0, 1'b1, 1'b0, 64'd0);
    check("first push popped", bus.data_out, 64'hABCD);

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].write, vecs[i].read, vecs[i].stall, vecs[i].din);
      check($sformatf("vec%0d data_out", i), bus.data_out, vecs[i].exp_dout);
      check($sformatf("vec%0d buf_full", i), fetch_t'(bus.buf_full), fetch_t'(vecs[i].exp_full));
    end

    // Fill 1..8, drop 99, drain in order.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b0, fetch_t'(i));
      check($sformatf("fill%0d buf_full", i), fetch_t'(bus.buf_full), (i == 8) ? 64'd1 : 64'd0);
    end
    step(1'b1, 1'b0, 1'b0, 64'd99);
    check("write while full", fetch_t'(bus.buf_full), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'd0);
      check($sformatf("drain%0d data_out", i), bus.data_out, fetch_t'(i));
    end
    check("drained buf_full", fetch_t'(bus.buf_full), 64'd0);
    step(1'b0, 1'b1, 1'b0, 64'd0);
    check("dropped 99 absent", bus.data_out, 64'd8);

    // Interleaved stream with two entries of slack to wrap both pointers.
    step(1'b1, 1'b0, 1'b0, 64'd200);
    step(1'b1, 1'b0, 1'b0, 64'd201);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, fetch_t'(202 + i));
      check($sformatf("wrap%0d data_out", i), bus.data_out, fetch_t'(200 + i));
    end
    step(1'b0, 1'b1, 1'b0, 64'd0);
    check("tail0 data_out", bus.data_out, 64'd220);
    step(1'b0, 1'b1, 1'b0, 64'd0);
    check("tail1 data_out", bus.data_out, 64'd221);
    step(1'b0, 1'b1, 1'b0, 64'd0);
    check("underflow hold", bus.data_out, 64'd221);

    // Fill to full, then assert reset between edges.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, fetch_t'(300 + i));
    check("prefill full", fetch_t'(bus.buf_full), 64'd1);
    bus.write = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset buf_full", fetch_t'(bus.buf_full), 64'd0);
    check("async reset data_out", bus.data_out, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 64'd0);
    check("post reset empty read", bus.data_out, 64'd0);
    step(1'b1, 1'b0, 1'b0, 64'd42);
    step(1'b0, 1'b1, 1'b0, 64'd0);
    check("post reset push/pop", bus.data_out, 64'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
